// File: rtl/usr_sequencer.sv
// -----------------------------------------------------------------------------
// usr_sequencer
//
// Purpose:
//   Sequencer for an external universal shift register. It accepts one
//   operation at a time and runs these steps:
//     1. Parallel-load the operand.
//     2. Apply 'count' shift or rotate steps.
//     3. Capture the register output.
//     4. Pulse 'done'.
//   A rotate is built from the register's plain shift modes. The bit that
//   falls off one end of q is fed back into the serial input at the other end.
//
// Parameters:
//   WIDTH  data width of the controlled shift register
//   CNT_W  width of the shift-count field
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       operation request, sampled in IDLE only
//   cmd[1:0]    00 shift right, 01 shift left, 10 rotate right, 11 rotate left
//   count       number of shift cycles (0 .. 2^CNT_W-1)
//   load_data   operand parallel-loaded into the register
//   fill        serial fill bit used by the plain shift commands
//   q           register output fed back from the shift register
//   abort       (USR_SEQ_ABORT_EN only) abandon the running operation
//   sel[1:0]    register mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   D           parallel-load data to the register
//   data_in_sr  serial input for right shift (enters at MSB)
//   data_in_sl  serial input for left shift (enters at LSB)
//   busy        operation in progress
//   done        one-cycle completion pulse
//   result      register value captured at the end of the last operation
//
// Configuration macro:
//   USR_SEQ_ABORT_EN  when defined, adds the 'abort' input and its logic.
//
// Output policy:
//   busy, sel and D are decoded from registered state only. data_in_sr and
//   data_in_sl are also decoded from registered state, plus q when rotating.
//   q must pass through combinationally, because the rotated bit has to
//   reach the register in the same cycle that it shifts.
//   done and result are registers.
// -----------------------------------------------------------------------------
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             fill,
    input  logic [WIDTH-1:0] q,
`ifdef USR_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] D,
    output logic             data_in_sr,
    output logic             data_in_sl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_SHIFT   = 2'b10,
        ST_CAPTURE = 2'b11
    } state_t;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic [1:0] CMD_SHR = 2'b00;
    localparam logic [1:0] CMD_SHL = 2'b01;
    localparam logic [1:0] CMD_ROR = 2'b10;
    localparam logic [1:0] CMD_ROL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next_run;   // next state when no abort is pending
    state_t            w_next;
    logic [1:0]        r_cmd;
    logic [WIDTH-1:0]  r_load_data;
    logic              r_fill;
    logic [CNT_W-1:0]  r_cnt;        // shifts still to perform
    logic              w_abort;
    logic              w_capture;

`ifdef USR_SEQ_ABORT_EN
    // Abort only acts on a running operation; in IDLE it is ignored.
    assign w_abort = abort && (r_state != ST_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // The capture is skipped when an abort lands in the CAPTURE cycle.
    assign w_capture = (r_state == ST_CAPTURE) && !w_abort;

    // Next-state logic for an uninterrupted operation.
    always_comb begin
        w_next_run = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_run = ST_LOAD;
                end else begin
                    w_next_run = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (r_cnt != CNT_ZERO) begin
                    w_next_run = ST_SHIFT;
                end else begin
                    w_next_run = ST_CAPTURE;
                end
            end
            ST_SHIFT: begin
                // The last shift happens on this edge when one step remains.
                if (r_cnt == CNT_ONE) begin
                    w_next_run = ST_CAPTURE;
                end else begin
                    w_next_run = ST_SHIFT;
                end
            end
            ST_CAPTURE: begin
                w_next_run = ST_IDLE;
            end
            default: begin
                w_next_run = ST_IDLE;
            end
        endcase
    end

    // An abort overrides the normal sequence.
    always_comb begin
        w_next = w_next_run;
        if (w_abort) begin
            w_next = ST_IDLE;
        end else begin
            w_next = w_next_run;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the operation fields on an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd       <= 2'b00;
            r_load_data <= {WIDTH{1'b0}};
            r_fill      <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cmd       <= cmd;
            r_load_data <= load_data;
            r_fill      <= fill;
        end else begin
            r_cmd       <= r_cmd;
            r_load_data <= r_load_data;
            r_fill      <= r_fill;
        end
    end

    // Remaining-shift down-counter.
    // It loads at start and decrements once per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cnt <= count;
        end else if ((r_state == ST_SHIFT) && (r_cnt != CNT_ZERO)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Completion pulse and captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done   <= 1'b0;
            result <= {WIDTH{1'b0}};
        end else if (w_capture) begin
            done   <= 1'b1;
            result <= q;
        end else begin
            done   <= 1'b0;
            result <= result;
        end
    end

    // Register-control decode from the current state and latched command.
    always_comb begin
        sel        = SEL_HOLD;
        D          = {WIDTH{1'b0}};
        data_in_sr = 1'b0;
        data_in_sl = 1'b0;
        case (r_state)
            ST_LOAD: begin
                sel = SEL_LOAD;
                D   = r_load_data;
            end
            ST_SHIFT: begin
                case (r_cmd)
                    CMD_SHR: begin
                        sel        = SEL_RIGHT;
                        data_in_sr = r_fill;
                    end
                    CMD_SHL: begin
                        sel        = SEL_LEFT;
                        data_in_sl = r_fill;
                    end
                    CMD_ROR: begin
                        // The LSB leaving on the right re-enters at the MSB.
                        sel        = SEL_RIGHT;
                        data_in_sr = q[0];
                    end
                    CMD_ROL: begin
                        // The MSB leaving on the left re-enters at the LSB.
                        sel        = SEL_LEFT;
                        data_in_sl = q[WIDTH-1];
                    end
                    default: begin
                        sel = SEL_HOLD;
                    end
                endcase
            end
            ST_CAPTURE: begin
                sel = SEL_HOLD;
            end
            default: begin
                sel = SEL_HOLD;
            end
        endcase
    end

    // busy covers LOAD, SHIFT and CAPTURE.
    always_comb begin
        busy = 1'b0;
        if (r_state != ST_IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_usr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usr_sequencer
//
// Directed bench for usr_sequencer (WIDTH=4, CNT_W=3).
// A small behavioural universal shift register closes the q loop.
// Expected results are hand-computed constants.
// Cycle k means the k-th cycle after the edge that samples start.
// It is observed at the k-th falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usr_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [2:0] count = 3'd0;
    logic [3:0] load_data = 4'b0000;
    logic       fill = 1'b0;
    logic [3:0] q;
`ifdef USR_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [1:0] sel;
    logic [3:0] D;
    logic       data_in_sr;
    logic       data_in_sl;
    logic       busy;
    logic       done;
    logic [3:0] result;

    int n_cmp = 0;
    int n_err = 0;

    usr_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cmd        (cmd),
        .count      (count),
        .load_data  (load_data),
        .fill       (fill),
        .q          (q),
`ifdef USR_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .sel        (sel),
        .D          (D),
        .data_in_sr (data_in_sr),
        .data_in_sl (data_in_sl),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Behavioural universal shift register driven by the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'b0000;
        end else begin
            case (sel)
                2'b01:   q <= {data_in_sr, q[3:1]};
                2'b10:   q <= {q[2:0], data_in_sl};
                2'b11:   q <= D;
                default: q <= q;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one operation and waits for done, for at most 20 cycles.
    // It returns with the bench sitting at the falling edge of the done cycle.
    // It also returns the LOAD-cycle controls and whether a shift mode appeared.
    task automatic run_op(input logic [1:0] c, input logic [2:0] n, input logic [3:0] ld,
                          input logic f, output int done_cyc, output bit saw_shift,
                          output logic [1:0] load_sel, output logic [3:0] load_d);
        @(negedge clk);
        start = 1'b1; cmd = c; count = n; load_data = ld; fill = f;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = -1; saw_shift = 1'b0; load_sel = 2'b00; load_d = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                load_sel = sel;
                load_d   = D;
            end
            if (sel == 2'b01 || sel == 2'b10) saw_shift = 1'b1;
            if (done) begin
                done_cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int         dc;
        bit         ss;
        logic [1:0] ls;
        logic [3:0] ldv;
        int         pulses;

        // Reset state
        #1;
        check("rst_sel", sel, 2'b00);
        check("rst_D", D, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 4'b0000);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        // Shift right 1011, fill 0, count 1 -> 0101, done in cycle 4
        run_op(2'b00, 3'd1, 4'b1011, 1'b0, dc, ss, ls, ldv);
        check("shr_done_cyc", dc, 4);
        check("shr_result", result, 4'b0101);
        check("shr_load_sel", ls, 2'b11);
        check("shr_load_D", ldv, 4'b1011);
        check("shr_busy_in_done", busy, 1'b0);
        @(negedge clk);
        check("shr_done_one_cycle", done, 1'b0);
        check("shr_result_hold", result, 4'b0101);

        // Rotate left 1001, count 2 -> 0110
        run_op(2'b11, 3'd2, 4'b1001, 1'b0, dc, ss, ls, ldv);
        check("rol_done_cyc", dc, 5);
        check("rol_result", result, 4'b0110);

        // Rotate right 1011, count 4 -> 1011
        run_op(2'b10, 3'd4, 4'b1011, 1'b0, dc, ss, ls, ldv);
        check("ror_done_cyc", dc, 7);
        check("ror_result", result, 4'b1011);

        // Shift left 0000, fill 1, count 3 -> 0111
        run_op(2'b01, 3'd3, 4'b0000, 1'b1, dc, ss, ls, ldv);
        check("shl_done_cyc", dc, 6);
        check("shl_result", result, 4'b0111);

        // count 0 with load 1100: done in cycle 3, no shift mode seen
        run_op(2'b00, 3'd0, 4'b1100, 1'b1, dc, ss, ls, ldv);
        check("cnt0_done_cyc", dc, 3);
        check("cnt0_result", result, 4'b1100);
        check("cnt0_no_shift", ss, 1'b0);

        // Second start during SHIFT is ignored.
        // The first op, shift left 0011 with fill 0 and count 3, ends as 1000.
        @(negedge clk);
        start = 1'b1; cmd = 2'b01; count = 3'd3; load_data = 4'b0011; fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0; dc = -1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 2) begin
                start = 1'b1; cmd = 2'b00; count = 3'd1; load_data = 4'b1111; fill = 1'b1;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                pulses++;
                if (dc < 0) dc = k;
            end
        end
        check("busy_start_pulses", pulses, 1);
        check("busy_start_done_cyc", dc, 6);
        check("busy_start_result", result, 4'b1000);

        // A start held in the done cycle is accepted.
        // Op A: shift right 1011, fill 0, count 1 -> 0101.
        // Op B: count 0, load 0110 -> 0110.
        run_op(2'b00, 3'd1, 4'b1011, 1'b0, dc, ss, ls, ldv);
        check("b2b_a_result", result, 4'b0101);
        start = 1'b1; cmd = 2'b00; count = 3'd0; load_data = 4'b0110; fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_busy_next", busy, 1'b1);
        check("b2b_load_sel", sel, 2'b11);
        dc = -1;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin
                dc = k;
                break;
            end
        end
        check("b2b_b_done_cyc", dc, 3);
        check("b2b_b_result", result, 4'b0110);

        // Reset pulsed during the SHIFT of a count-5 operation.
        // The op is shift right 1111 with fill 1, so data_in_sr is 1 while shifting.
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; count = 3'd5; load_data = 4'b1111; fill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("pre_rst_sr", data_in_sr, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", sel, 2'b00);
        check("async_rst_D", D, 4'b0000);
        check("async_rst_sr", data_in_sr, 1'b0);
        check("async_rst_sl", data_in_sl, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_result", result, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        check("rst_idle_busy", busy, 1'b0);
        // Shift right 1000 with fill 1 and count 2 gives 1100, then 1110.
        run_op(2'b00, 3'd2, 4'b1000, 1'b1, dc, ss, ls, ldv);
        check("post_rst_done_cyc", dc, 5);
        check("post_rst_result", result, 4'b1110);

`ifdef USR_SEQ_ABORT_EN
        // Abort during SHIFT: the FSM goes to IDLE, with no done and result kept.
        @(negedge clk);
        start = 1'b1; cmd = 2'b00; count = 3'd5; load_data = 4'b1111; fill = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_sel", sel, 2'b00);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);
        check("abort_result_kept", result, 4'b1110);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usr_sequencer.md
USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the data width of the controlled universal shift register.
REQ-002 The block SHALL have parameter CNT_W, default 3, meaning the width of the shift-count field.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high: clk input 1 (sole clock, rising edge); rst input 1 (asynchronous, active-high).
REQ-004 The block SHALL have these ports:
- start input 1: request, sampled in IDLE.
- cmd input 2: operation. 00 shift right; 01 shift left; 10 rotate right; 11 rotate left.
- count input CNT_W: number of shift cycles, 0..2^CNT_W-1.
- load_data input WIDTH: operand to parallel-load.
- fill input 1: serial fill bit for shift commands.
- q input WIDTH: register output fed back from the shift register.
- sel output 2: mode select to the register. 00 hold; 01 shift right; 10 shift left; 11 parallel load.
- D output WIDTH: parallel-load data to the register.
- data_in_sr output 1: serial input for right shift, enters at MSB.
- data_in_sl output 1: serial input for left shift, enters at LSB.
- busy output 1: operation in progress.
- done output 1: one-cycle completion pulse.
- result output WIDTH: captured final register value.

Function
REQ-005 The block SHALL implement the FSM states IDLE, LOAD, SHIFT and CAPTURE, and SHALL register all outputs or decode them from the registered state only.
REQ-006 In IDLE with start=1, the block SHALL latch cmd, count, load_data and fill, and SHALL go to LOAD on the next edge.
REQ-007 In IDLE, start=0 SHALL keep the FSM in IDLE.
REQ-008 LOAD SHALL last exactly one cycle and SHALL drive sel=11 and D=latched load_data.
REQ-009 LOAD SHALL go to SHIFT if the latched count is nonzero, else to CAPTURE.
REQ-010 SHIFT SHALL last exactly count cycles.
REQ-011 In SHIFT, the block SHALL drive sel=01 for cmd 00 or 10, and sel=10 for cmd 01 or 11.
REQ-012 In SHIFT, the serial inputs SHALL be driven as follows:
- cmd 00: data_in_sr=fill.
- cmd 01: data_in_sl=fill.
- cmd 10: data_in_sr=q[0].
- cmd 11: data_in_sl=q[WIDTH-1].
- The unused serial input SHALL be 0.
REQ-013 An internal down-counter SHALL track the remaining shifts and SHALL go to CAPTURE on the edge where the last shift occurs.
REQ-014 CAPTURE SHALL last one cycle and SHALL drive sel=00.
REQ-015 On the edge leaving CAPTURE, the block SHALL set result<=q and done<=1, and the FSM SHALL return to IDLE.
REQ-016 done SHALL be high for exactly one cycle.
REQ-017 result SHALL hold its value until the next capture.
REQ-018 Timing: with start sampled at edge 0, done SHALL be high in cycle count+3 (cycle 3 when count=0).
REQ-019 busy SHALL be 1 in LOAD, SHIFT and CAPTURE, and 0 otherwise.
REQ-020 busy SHALL be 0 in the cycle done is high.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 start in the cycle done is high SHALL be accepted.
REQ-023 In IDLE, the block SHALL drive sel=00, D=0 and data_in_sr=data_in_sl=0.

Reset
REQ-024 rst=1 SHALL immediately force the state to IDLE, independent of clk.
REQ-025 rst=1 SHALL immediately force sel=00, D=0, data_in_sr=0, data_in_sl=0, busy=0, done=0, result=0 and counter=0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no done pulse.
REQ-027 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-028 Macro USR_SEQ_ABORT_EN, when defined, SHALL add input port abort (1 bit).
REQ-029 With USR_SEQ_ABORT_EN defined, abort=1 sampled in LOAD, SHIFT or CAPTURE SHALL return the FSM to IDLE on the next edge with sel=00, no done pulse and result unchanged.
REQ-030 With USR_SEQ_ABORT_EN defined, abort=1 in IDLE SHALL have no effect.
REQ-031 With USR_SEQ_ABORT_EN defined, abort SHALL take priority over start.
REQ-032 When USR_SEQ_ABORT_EN is undefined, the abort port and its logic SHALL be absent, and operations SHALL always run to completion.

Verification
REQ-033 The bench SHALL cover: load_data=1011, cmd=00, fill=0, count=1 -> result=0101, done in cycle 4.
REQ-034 The bench SHALL cover: load_data=1001, cmd=11, count=2 -> result=0110; and load_data=1011, cmd=10, count=4 -> result=1011.
REQ-035 The bench SHALL cover: load_data=0000, cmd=01, fill=1, count=3 -> result=0111; and count=0 with load_data=1100 -> result=1100, done in cycle 3, no SHIFT cycle (sel never 01/10).
REQ-036 The bench SHALL cover: second start pulsed during SHIFT -> ignored, one done; start held in the done cycle -> new operation begins, busy=1 the next cycle.
REQ-037 The bench SHALL cover: rst pulsed during SHIFT of count=5 -> all outputs 0 asynchronously, no done, and the next start completes correctly.
REQ-038 The bench SHALL cover, with USR_SEQ_ABORT_EN defined: abort during SHIFT -> IDLE next cycle, done stays 0, result keeps its prior value.
